codec_cfg_sequencer: RTL and testbench
======================================

CODEC_CFG_SEQUENCER -- requirements
Module: codec_cfg_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20'd1000000, max cycles a single CODEC access may keep controller_busy high.
REQ-002 Parameter MAX_RETRY, default 2, re-issues of an init entry after missed_ack before giving up.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 start_init  in  1  one-cycle pulse; runs the power-up init table.
REQ-006 host_req  in  1  level; held high until host_ack.
REQ-007 host_rd  in  1  1 = read, 0 = write; valid with host_req.
REQ-008 host_addr  in  7  CODEC register index.
REQ-009 host_wdata  in  9  write data.
REQ-010 host_ack  out  1  one-cycle pulse; host access complete.
REQ-011 host_rdata  out  9  read data, valid with host_ack on reads.
REQ-012 host_err  out  1  valid with host_ack; missed_ack or timeout.
REQ-013 codec_rd_en / codec_wr_en  out  1 each  one-cycle request pulses to the I2C sequencer.
REQ-014 codec_reg_addr  out  8  {1'b0, addr[6:0]}.
REQ-015 codec_data_in  out  9  write data.
REQ-016 codec_data_out  in  9; codec_data_out_valid  in  1  read return.
REQ-017 controller_busy  in  1; missed_ack  in  1  sequencer status (missed_ack sticky).
REQ-018 init_done  out  1; init_error  out  1; busy  out  1  status levels.

Function
REQ-019 Init table: 10 fixed {addr, data} entries in order: 0F/000, 06/010, 00/017, 01/017, 04/012, 05/000, 07/00A, 08/000, 09/001, 06/000.
REQ-020 States: IDLE, ARB, ISSUE, WAIT_HI, WAIT_LO, CHECK, DONE.
REQ-021 IDLE->ARB when init is pending or host_req=1; init pending is set by start_init, cleared when the sequence finishes.
REQ-022 ARB priority: a pending init always beats host_req.
- Host waits through a whole init run.
- start_init during a host access is latched and starts after that access's host_ack.
REQ-023 ISSUE drives exactly one rd_en/wr_en pulse, with addr/data held stable from ISSUE until the end of WAIT_LO. Init entries are always writes.
REQ-024 WAIT_HI waits for controller_busy=1.
- Goes to WAIT_LO when busy is seen.
- If busy is not seen within 8 cycles of the pulse, the access counts as a timeout failure.
REQ-025 WAIT_LO counts cycles while busy=1.
- busy=0 -> CHECK.
- Count reaching TIMEOUT_CYCLES -> failure; the FSM stays in WAIT_LO until busy=0 and issues nothing new.
REQ-026 On reads, codec_data_out is captured on any cycle with codec_data_out_valid=1 in WAIT_HI/WAIT_LO/CHECK. If none is seen, host_rdata=0 and host_err=1.
REQ-027 CHECK samples missed_ack one cycle after busy falls. Access failure = missed_ack=1 or a timeout.
REQ-028 Host access: CHECK->DONE.
- DONE pulses host_ack for one cycle with host_err and host_rdata, then goes to IDLE.
- host_req must be low or a new request by the next ARB.
REQ-029 Init access:
- Success -> index+1, retry count cleared, back to ISSUE.
- Failure with retries < MAX_RETRY -> retry+1, re-ISSUE the same entry.
- Failure otherwise -> init_error=1, init_done=0, abort to IDLE.
- After entry 9 succeeds -> init_done=1.
REQ-030 start_init clears init_done and init_error, resets index and retry to 0. A start_init during an init run is ignored.
REQ-031 busy=1 in every state except IDLE.
REQ-032 Timeout counter is 20 bits and saturates. It clears at each ISSUE.

Reset
REQ-033 reset_n=0 on a clk edge puts the FSM in IDLE with all outputs 0, counters 0, pending flags 0. This holds mid-transfer: no further pulses are issued after reset, even if controller_busy is still high.

Verification
REQ-034 start_init, model acks each write (busy high 5 cycles, missed_ack=0) -> 10 writes in table order, e.g. first addr 0x0F data 0x000; init_done=1 after the 10th.
REQ-035 Host read addr 0x07 with model returning 0x00A -> codec_rd_en once, codec_reg_addr=0x07, host_ack with host_rdata=0x00A, host_err=0.
REQ-036 host_req held during init -> host access issued only after init_done=1; exactly one host_ack.
REQ-037 missed_ack=1 on entry 3 forever -> entry 3 issued 3 times, init_error=1, no entry 4.
REQ-038 controller_busy stuck high on a host write -> host_ack with host_err=1 only after busy drops; no extra enables. Separately, busy never rising -> host_err=1 within 10 cycles.
REQ-039 reset_n low during WAIT_LO of init entry 5 -> all outputs 0 next cycle; next start_init restarts at entry 0.

Source files
------------

// File: rtl/codec_cfg_sequencer.sv
// CODEC configuration sequencer: replays a fixed power-up register table and
// arbitrates single host register accesses onto an I2C command sequencer.
module codec_cfg_sequencer #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_init,
    input  logic       host_req,
    input  logic       host_rd,
    input  logic [6:0] host_addr,
    input  logic [8:0] host_wdata,
    output logic       host_ack,
    output logic [8:0] host_rdata,
    output logic       host_err,
    output logic       codec_rd_en,
    output logic       codec_wr_en,
    output logic [7:0] codec_reg_addr,
    output logic [8:0] codec_data_in,
    input  logic [8:0] codec_data_out,
    input  logic       codec_data_out_valid,
    input  logic       controller_busy,
    input  logic       missed_ack,
    output logic       init_done,
    output logic       init_error,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        ISSUE   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [3:0] MAX_RETRY_L = 4'(MAX_RETRY);

    function automatic logic [15:0] init_entry(input logic [3:0] i);
        case (i)
            4'd0:    return {7'h0F, 9'h000};
            4'd1:    return {7'h06, 9'h010};
            4'd2:    return {7'h00, 9'h017};
            4'd3:    return {7'h01, 9'h017};
            4'd4:    return {7'h04, 9'h012};
            4'd5:    return {7'h05, 9'h000};
            4'd6:    return {7'h07, 9'h00A};
            4'd7:    return {7'h08, 9'h000};
            4'd8:    return {7'h09, 9'h001};
            4'd9:    return {7'h06, 9'h000};
            default: return 16'h0000;
        endcase
    endfunction

    state_t      state_r, state_s;
    logic        init_pend_r, init_pend_s;
    logic        init_acc_r, init_acc_s;
    logic        is_rd_r, is_rd_s;
    logic [6:0]  addr_r, addr_s;
    logic [8:0]  wdata_r, wdata_s;
    logic [3:0]  idx_r, idx_s;
    logic [3:0]  retry_r, retry_s;
    logic [2:0]  hi_cnt_r, hi_cnt_s;
    logic [19:0] tmo_cnt_r, tmo_cnt_s;
    logic        tmo_fail_r, tmo_fail_s;
    logic [8:0]  rdata_r, rdata_s;
    logic        rd_seen_r, rd_seen_s;
    logic        init_done_r, init_done_s;
    logic        init_error_r, init_error_s;
    logic        host_ack_r, host_ack_s;
    logic        host_err_r, host_err_s;
    logic [8:0]  host_rdata_r, host_rdata_s;
    logic        rd_en_r, rd_en_s;
    logic        wr_en_r, wr_en_s;
    logic        busy_r, busy_s;
    logic        cap_s;
    logic        acc_fail_s;

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_s      = state_r;
        init_pend_s  = init_pend_r;
        init_acc_s   = init_acc_r;
        is_rd_s      = is_rd_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        idx_s        = idx_r;
        retry_s      = retry_r;
        hi_cnt_s     = hi_cnt_r;
        tmo_cnt_s    = tmo_cnt_r;
        tmo_fail_s   = tmo_fail_r;
        rdata_s      = rdata_r;
        rd_seen_s    = rd_seen_r;
        init_done_s  = init_done_r;
        init_error_s = init_error_r;
        host_err_s   = 1'b0;
        host_rdata_s = 9'd0;
        acc_fail_s   = 1'b0;

        cap_s = is_rd_r && codec_data_out_valid &&
                ((state_r == WAIT_HI) || (state_r == WAIT_LO) || (state_r == CHECK));
        if (cap_s) begin
            rdata_s   = codec_data_out;
            rd_seen_s = 1'b1;
        end else begin
            rd_seen_s = rd_seen_r;
        end

        // a start request while a table run is pending or active is dropped
        if (start_init && !init_pend_r) begin
            init_pend_s  = 1'b1;
            idx_s        = 4'd0;
            retry_s      = 4'd0;
            init_done_s  = 1'b0;
            init_error_s = 1'b0;
        end else begin
            init_pend_s  = init_pend_r;
        end

        case (state_r)
            IDLE: begin
                if (init_pend_r || host_req) state_s = ARB;
                else                         state_s = IDLE;
            end
            ARB: begin
                if (init_pend_r) begin
                    init_acc_s        = 1'b1;
                    is_rd_s           = 1'b0;
                    {addr_s, wdata_s} = init_entry(idx_r);
                    state_s           = ISSUE;
                end else if (host_req) begin
                    init_acc_s = 1'b0;
                    is_rd_s    = host_rd;
                    addr_s     = host_addr;
                    wdata_s    = host_wdata;
                    state_s    = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = WAIT_HI;
            WAIT_HI: begin
                if (controller_busy) begin
                    state_s = WAIT_LO;
                end else if (hi_cnt_r == 3'd7) begin
                    tmo_fail_s = 1'b1;
                    state_s    = CHECK;
                end else begin
                    hi_cnt_s = hi_cnt_r + 3'd1;
                end
            end
            WAIT_LO: begin
                if (!controller_busy) begin
                    state_s = CHECK;
                end else begin
                    if (tmo_cnt_r != 20'hFFFFF) tmo_cnt_s = tmo_cnt_r + 20'd1;
                    else                        tmo_cnt_s = tmo_cnt_r;
                    if (tmo_cnt_s >= TIMEOUT_CYCLES) tmo_fail_s = 1'b1;
                    else                             tmo_fail_s = tmo_fail_r;
                end
            end
            CHECK: begin
                acc_fail_s = missed_ack || tmo_fail_r || (is_rd_r && !rd_seen_s);
                if (!init_acc_r) begin
                    host_err_s   = acc_fail_s;
                    host_rdata_s = (is_rd_r && rd_seen_s) ? rdata_s : 9'd0;
                    state_s      = DONE;
                end else if (!acc_fail_s) begin
                    if (idx_r == 4'd9) begin
                        init_done_s = 1'b1;
                        init_pend_s = 1'b0;
                        init_acc_s  = 1'b0;
                        state_s     = IDLE;
                    end else begin
                        idx_s             = idx_r + 4'd1;
                        retry_s           = 4'd0;
                        {addr_s, wdata_s} = init_entry(idx_r + 4'd1);
                        state_s           = ISSUE;
                    end
                end else if (retry_r < MAX_RETRY_L) begin
                    retry_s = retry_r + 4'd1;
                    state_s = ISSUE;
                end else begin
                    init_error_s = 1'b1;
                    init_done_s  = 1'b0;
                    init_pend_s  = 1'b0;
                    init_acc_s   = 1'b0;
                    state_s      = IDLE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase

        // every access starts with fresh watchdogs and read-capture state
        if (state_s == ISSUE) begin
            hi_cnt_s   = 3'd0;
            tmo_cnt_s  = 20'd0;
            tmo_fail_s = 1'b0;
            rd_seen_s  = 1'b0;
            rdata_s    = 9'd0;
        end else begin
            hi_cnt_s   = hi_cnt_s;
        end

        rd_en_s    = (state_s == ISSUE) && is_rd_s;
        wr_en_s    = (state_s == ISSUE) && !is_rd_s;
        host_ack_s = (state_s == DONE);
        busy_s     = (state_s != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            init_pend_r  <= 1'b0;
            init_acc_r   <= 1'b0;
            is_rd_r      <= 1'b0;
            addr_r       <= 7'd0;
            wdata_r      <= 9'd0;
            idx_r        <= 4'd0;
            retry_r      <= 4'd0;
            hi_cnt_r     <= 3'd0;
            tmo_cnt_r    <= 20'd0;
            tmo_fail_r   <= 1'b0;
            rdata_r      <= 9'd0;
            rd_seen_r    <= 1'b0;
            init_done_r  <= 1'b0;
            init_error_r <= 1'b0;
            host_ack_r   <= 1'b0;
            host_err_r   <= 1'b0;
            host_rdata_r <= 9'd0;
            rd_en_r      <= 1'b0;
            wr_en_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            init_pend_r  <= init_pend_s;
            init_acc_r   <= init_acc_s;
            is_rd_r      <= is_rd_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            idx_r        <= idx_s;
            retry_r      <= retry_s;
            hi_cnt_r     <= hi_cnt_s;
            tmo_cnt_r    <= tmo_cnt_s;
            tmo_fail_r   <= tmo_fail_s;
            rdata_r      <= rdata_s;
            rd_seen_r    <= rd_seen_s;
            init_done_r  <= init_done_s;
            init_error_r <= init_error_s;
            host_ack_r   <= host_ack_s;
            host_err_r   <= host_err_s;
            host_rdata_r <= host_rdata_s;
            rd_en_r      <= rd_en_s;
            wr_en_r      <= wr_en_s;
            busy_r       <= busy_s;
        end
    end

    assign host_ack       = host_ack_r;
    assign host_err       = host_err_r;
    assign host_rdata     = host_rdata_r;
    assign codec_rd_en    = rd_en_r;
    assign codec_wr_en    = wr_en_r;
    assign codec_reg_addr = {1'b0, addr_r};
    assign codec_data_in  = wdata_r;
    assign init_done      = init_done_r;
    assign init_error     = init_error_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer with a behavioural I2C sequencer
// responder that logs every enable pulse it receives.
module tb_codec_cfg_sequencer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_init;
    logic       host_req;
    logic       host_rd;
    logic [6:0] host_addr;
    logic [8:0] host_wdata;
    logic       host_ack;
    logic [8:0] host_rdata;
    logic       host_err;
    logic       codec_rd_en;
    logic       codec_wr_en;
    logic [7:0] codec_reg_addr;
    logic [8:0] codec_data_in;
    logic [8:0] codec_data_out;
    logic       codec_data_out_valid;
    logic       controller_busy;
    logic       missed_ack;
    logic       init_done;
    logic       init_error;
    logic       busy;

    codec_cfg_sequencer #(.TIMEOUT_CYCLES(20'd40), .MAX_RETRY(2)) dut (
        .clk(clk), .reset_n(reset_n), .start_init(start_init),
        .host_req(host_req), .host_rd(host_rd), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .host_err(host_err), .codec_rd_en(codec_rd_en), .codec_wr_en(codec_wr_en),
        .codec_reg_addr(codec_reg_addr), .codec_data_in(codec_data_in),
        .codec_data_out(codec_data_out), .codec_data_out_valid(codec_data_out_valid),
        .controller_busy(controller_busy), .missed_ack(missed_ack),
        .init_done(init_done), .init_error(init_error), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [6:0] exp_addr [0:9] = '{7'h0F, 7'h06, 7'h00, 7'h01, 7'h04, 7'h05, 7'h07, 7'h08, 7'h09, 7'h06};
    logic [8:0] exp_data [0:9] = '{9'h000, 9'h010, 9'h017, 9'h017, 9'h012, 9'h000, 9'h00A, 9'h000, 9'h001, 9'h000};

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] log_addr [0:127];
    logic [8:0] log_data [0:127];
    logic       log_rd   [0:127];
    logic       log_done [0:127];
    int         log_cyc  [0:127];
    int         pulse_cnt = 0;
    int         both_cnt  = 0;
    int         ack_cnt   = 0;
    int         busy_cnt  = 0;
    logic       pend_rd   = 1'b0;
    logic       fail_en   = 1'b0;
    logic       stuck_mode = 1'b0;
    logic       never_mode = 1'b0;
    logic [8:0] model_rdata = 9'h000;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Responder: busy high 5 cycles per command, read data returned while busy.
    initial begin
        controller_busy      = 1'b0;
        missed_ack           = 1'b0;
        codec_data_out       = 9'd0;
        codec_data_out_valid = 1'b0;
        forever begin
            @(negedge clk);
            codec_data_out_valid = 1'b0;
            if (codec_wr_en || codec_rd_en) begin
                if (pulse_cnt < 128) begin
                    log_addr[pulse_cnt] = codec_reg_addr;
                    log_data[pulse_cnt] = codec_data_in;
                    log_rd[pulse_cnt]   = codec_rd_en;
                    log_done[pulse_cnt] = init_done;
                    log_cyc[pulse_cnt]  = cyc;
                end
                pulse_cnt++;
                if (codec_wr_en && codec_rd_en) both_cnt++;
                pend_rd    = codec_rd_en;
                missed_ack = fail_en && (codec_reg_addr == 8'h01);
                if (!never_mode) begin
                    controller_busy = 1'b1;
                    busy_cnt        = 5;
                end
            end else if (busy_cnt > 0 && !stuck_mode) begin
                busy_cnt--;
                if (pend_rd && busy_cnt == 1) begin
                    codec_data_out_valid = 1'b1;
                    codec_data_out       = model_rdata;
                end
                if (busy_cnt == 0) controller_busy = 1'b0;
            end
            if (host_ack) ack_cnt++;
        end
    end

    task automatic run_init(input int max_cyc, output logic ended);
        start_init = 1'b1;
        @(posedge clk); #2;
        start_init = 1'b0;
        ended = 1'b0;
        for (int i = 0; i < max_cyc && !ended; i++) begin
            @(posedge clk); #2;
            if (!busy && (init_done || init_error)) ended = 1'b1;
        end
    endtask

    task automatic wait_ack(input int max_cyc, output logic got, output logic err,
                            output logic [8:0] rd, output int at_cyc);
        got = 1'b0; err = 1'b0; rd = 9'd0; at_cyc = 0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(posedge clk); #2;
            if (host_ack) begin
                got = 1'b1; err = host_err; rd = host_rdata; at_cyc = cyc;
                host_req = 1'b0;
            end
        end
        host_req = 1'b0;
    endtask

    task automatic host_access(input logic rd, input logic [6:0] a, input logic [8:0] d,
                               output logic got, output logic err, output logic [8:0] rdat,
                               output int at_cyc);
        host_req = 1'b1; host_rd = rd; host_addr = a; host_wdata = d;
        wait_ack(60, got, err, rdat, at_cyc);
    endtask

    task automatic check_idle_outputs(input string pfx);
        check_val({pfx, "_host_ack"}, 32'(host_ack), 32'd0);
        check_val({pfx, "_host_err"}, 32'(host_err), 32'd0);
        check_val({pfx, "_host_rdata"}, 32'(host_rdata), 32'd0);
        check_val({pfx, "_rd_en"}, 32'(codec_rd_en), 32'd0);
        check_val({pfx, "_wr_en"}, 32'(codec_wr_en), 32'd0);
        check_val({pfx, "_reg_addr"}, 32'(codec_reg_addr), 32'd0);
        check_val({pfx, "_data_in"}, 32'(codec_data_in), 32'd0);
        check_val({pfx, "_init_done"}, 32'(init_done), 32'd0);
        check_val({pfx, "_init_error"}, 32'(init_error), 32'd0);
        check_val({pfx, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_table(input string pfx, input int base);
        for (int i = 0; i < 10; i++) begin
            check_val($sformatf("%s_e%0d_addr", pfx, i), 32'(log_addr[base + i]), 32'({1'b0, exp_addr[i]}));
            check_val($sformatf("%s_e%0d_data", pfx, i), 32'(log_data[base + i]), 32'(exp_data[i]));
        end
    endtask

    initial begin
        logic       ended, got, err;
        logic [8:0] rdat;
        int         at_cyc, base, n01, n04;

        reset_n = 1'b0; start_init = 1'b0; host_req = 1'b0; host_rd = 1'b0;
        host_addr = 7'd0; host_wdata = 9'd0;
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #2;

        // full init run, every write acknowledged
        base = pulse_cnt;
        run_init(400, ended);
        check_val("init_finished", 32'(ended), 32'd1);
        check_val("init_pulses", 32'(pulse_cnt - base), 32'd10);
        check_table("init", base);
        check_val("init_done", 32'(init_done), 32'd1);
        check_val("init_error_clear", 32'(init_error), 32'd0);

        // host read of register 0x07 returning 0x00A
        base = pulse_cnt;
        model_rdata = 9'h00A;
        host_access(1'b1, 7'h07, 9'h000, got, err, rdat, at_cyc);
        check_val("rd_ack", 32'(got), 32'd1);
        check_val("rd_rdata", 32'(rdat), 32'h00A);
        check_val("rd_err", 32'(err), 32'd0);
        check_val("rd_pulses", 32'(pulse_cnt - base), 32'd1);
        check_val("rd_is_read", 32'(log_rd[base]), 32'd1);
        check_val("rd_addr", 32'(log_addr[base]), 32'h07);

        // host write
        base = pulse_cnt;
        host_access(1'b0, 7'h05, 9'h1AB, got, err, rdat, at_cyc);
        check_val("wr_ack", 32'(got), 32'd1);
        check_val("wr_err", 32'(err), 32'd0);
        check_val("wr_is_write", 32'(log_rd[base]), 32'd0);
        check_val("wr_addr", 32'(log_addr[base]), 32'h05);
        check_val("wr_data", 32'(log_data[base]), 32'h1AB);

        // host request held across a whole init run
        repeat (3) @(posedge clk);
        #2;
        base = pulse_cnt;
        at_cyc = ack_cnt;
        host_req = 1'b1; host_rd = 1'b0; host_addr = 7'h0A; host_wdata = 9'h055;
        start_init = 1'b1;
        @(posedge clk); #2;
        start_init = 1'b0;
        wait_ack(400, got, err, rdat, n01);
        repeat (4) @(posedge clk);
        #2;
        check_val("hold_ack", 32'(got), 32'd1);
        check_val("hold_ack_count", 32'(ack_cnt - at_cyc), 32'd1);
        check_val("hold_pulses", 32'(pulse_cnt - base), 32'd11);
        check_table("hold", base);
        check_val("hold_host_addr", 32'(log_addr[base + 10]), 32'h0A);
        check_val("hold_host_after_done", 32'(log_done[base + 10]), 32'd1);

        // entry 3 never acknowledged
        fail_en = 1'b1;
        base = pulse_cnt;
        run_init(400, ended);
        n01 = 0; n04 = 0;
        for (int i = base; i < pulse_cnt; i++) begin
            if (log_addr[i] == 8'h01) n01++;
            if (log_addr[i] == 8'h04) n04++;
        end
        check_val("nak_finished", 32'(ended), 32'd1);
        check_val("nak_init_error", 32'(init_error), 32'd1);
        check_val("nak_init_done", 32'(init_done), 32'd0);
        check_val("nak_pulses", 32'(pulse_cnt - base), 32'd6);
        check_val("nak_entry3_tries", 32'(n01), 32'd3);
        check_val("nak_no_entry4", 32'(n04), 32'd0);
        fail_en = 1'b0;
        missed_ack = 1'b0;

        // controller_busy stuck high on a host write
        stuck_mode = 1'b1;
        base = pulse_cnt;
        at_cyc = ack_cnt;
        host_req = 1'b1; host_rd = 1'b0; host_addr = 7'h03; host_wdata = 9'h011;
        repeat (80) @(posedge clk);
        #2;
        check_val("stuck_no_early_ack", 32'(ack_cnt - at_cyc), 32'd0);
        stuck_mode = 1'b0;
        wait_ack(30, got, err, rdat, n01);
        check_val("stuck_ack", 32'(got), 32'd1);
        check_val("stuck_err", 32'(err), 32'd1);
        check_val("stuck_pulses", 32'(pulse_cnt - base), 32'd1);
        check_val("no_dual_enable", 32'(both_cnt), 32'd0);

        // controller_busy never rising
        never_mode = 1'b1;
        base = pulse_cnt;
        host_access(1'b0, 7'h02, 9'h0F0, got, err, rdat, at_cyc);
        check_val("never_ack", 32'(got), 32'd1);
        check_val("never_err", 32'(err), 32'd1);
        check_val("never_latency_ok", 32'((at_cyc - log_cyc[base]) <= 10), 32'd1);
        never_mode = 1'b0;

        // reset during WAIT_LO of entry 5, then a clean restart
        repeat (3) @(posedge clk);
        #2;
        base = pulse_cnt;
        start_init = 1'b1;
        @(posedge clk); #2;
        start_init = 1'b0;
        ended = 1'b0;
        for (int i = 0; i < 200 && !ended; i++) begin
            @(posedge clk); #2;
            if (pulse_cnt >= base + 6) ended = 1'b1;
        end
        check_val("mid_reach_entry5", 32'(ended), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        @(posedge clk); #2;
        check_idle_outputs("midrst");
        reset_n = 1'b1;
        base = pulse_cnt;
        repeat (10) @(posedge clk);
        #2;
        check_val("midrst_no_pulses", 32'(pulse_cnt - base), 32'd0);
        run_init(400, ended);
        check_val("restart_finished", 32'(ended), 32'd1);
        check_val("restart_pulses", 32'(pulse_cnt - base), 32'd10);
        check_val("restart_first_addr", 32'(log_addr[base]), 32'h0F);
        check_val("restart_first_data", 32'(log_data[base]), 32'h000);
        check_val("restart_done", 32'(init_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
